mux_scan_ctrl: RTL and testbench
================================

// Module: mux_scan_ctrl
// PURPOSE
//  Upstream sequencer for the 4:1 bit mux (4-bit data in, 2-bit select, 1-bit out).
//  Accepts a 4-bit word on a valid/ready handshake and holds it on the mux data inputs.
//  Steps the mux select through all four channels and samples the mux output once per channel.
//  Returns the reassembled word, a popcount and a self-check error flag on a valid/ready output.
// PARAMETERS
//  DWELL    1  clock cycles spent on each channel before its sample is taken; must be >= 1
//  REVERSE  0  0: select order 0,1,2,3; 1: select order 3,2,1,0
// PORTS
//  clk        in   1  single clock; all state updates on the rising edge
//  rst        in   1  synchronous, active-high reset
//  in_valid   in   1  data_in is valid
//  in_ready   out  1  block can accept a word; high only in IDLE
//  data_in    in   4  word to scan
//  mux_in     out  4  registered copy of the accepted word, drives the mux data input
//  mux_sel    out  2  registered select, drives the mux select
//  mux_out    in   1  mux result, sampled by this block
//  out_valid  out  1  result valid; high only in DONE
//  out_ready  in   1  consumer accepts the result
//  data_out   out  4  reassembled word; bit[i] = mux_out sampled while mux_sel == i
//  ones_cnt   out  3  number of 1 bits sampled (0..4)
//  err        out  1  high in DONE when data_out != mux_in
//  busy       out  1  high in SCAN or DONE
// BEHAVIOUR
//  Reset values: state IDLE; mux_in, mux_sel, data_out, ones_cnt and dwell counter are 0.
//    Reset also clears out_valid, err and busy; in_ready = 1 in the cycle after reset.
//  FSM states: IDLE, SCAN, DONE.
//  IDLE -> SCAN when in_valid && in_ready.
//    mux_in <= data_in; mux_sel <= (REVERSE ? 3 : 0); dwell counter <= 0.
//    data_out <= 0; ones_cnt <= 0.
//  SCAN: the dwell counter increments every cycle.
//    When it equals DWELL-1: data_out[mux_sel] <= mux_out; ones_cnt += mux_out; counter <= 0.
//    If that was the last channel (3, or 0 when REVERSE=1), go to DONE; else step mux_sel by +1 (-1 if REVERSE).
//  DONE: out_valid = 1; data_out, ones_cnt and err are held stable while out_valid && !out_ready.
//    On out_valid && out_ready go to IDLE. mux_in and mux_sel hold their last values until the next accept.
//  Latency: out_valid first high after exactly 4*DWELL+1 rising edges counted from the accepting edge.
//    This latency is fixed regardless of data.
//  mux_sel only changes on a dwell boundary, so the mux sees a stable select for exactly DWELL cycles per channel.
//  No bypass: in DONE with out_ready high, in_ready rises one cycle later (in IDLE), not the same cycle.
//  in_valid while busy is ignored; the upstream producer must hold data_in until in_ready is seen.
//  data_in == 0: the mux forces 0, so the result is data_out = 0, ones_cnt = 0, err = 0.
//    This input still takes the full scan latency.
//  Reset mid-scan or in DONE: the cycle in progress is abandoned. No out_valid is produced and all reset values apply.
//  err is combinational from registered state: (state == DONE) && (data_out != mux_in).
//  DWELL < 1 is an elaboration-time error.
// STRUCTURE
//  Package mux_scan_pkg holds:
//    NUM_CH = 4, SEL_W = 2, CNT_W = 3;
//    the state enum {IDLE, SCAN, DONE};
//    a function first_sel(REVERSE) and a function next_sel(sel, REVERSE).
//  Sub-module dwell_timer (parameter DWELL; ports clk, rst, clr, en, tick):
//    counts cycles and pulses tick on the cycle the count equals DWELL-1.
//  The top level contains the FSM, the select stepper and the capture/popcount registers.
//  The mux itself is instantiated only in the testbench, never inside this block.
// TESTING
//  T1 reset: assert rst for 2 cycles mid-SCAN
//     -> in_ready=1, out_valid=0, mux_sel=0, mux_in=0, data_out=0 on the next cycle.
//  T2 basic, DWELL=1 REVERSE=0, data_in=4'b1011
//     -> mux_sel 0,1,2,3 one cycle each; out_valid 5 edges after accept.
//     -> data_out=4'b1011, ones_cnt=3, err=0.
//  T3 DWELL=3 REVERSE=1, data_in=4'b0110
//     -> mux_sel 3,2,1,0 three cycles each; out_valid 13 edges after accept.
//     -> data_out=4'b0110, ones_cnt=2.
//  T4 zero word, data_in=4'b0000
//     -> full-latency scan; data_out=0, ones_cnt=0, err=0.
//  T5 backpressure: out_ready low 6 cycles in DONE, in_valid held high throughout
//     -> outputs stable, in_ready=0, no new accept; in_ready returns 1 cycle after out_ready.
//  T6 fault injection: testbench forces mux_out=0 during channel 2 for data_in=4'b1111
//     -> data_out=4'b1011, ones_cnt=3, err=1.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared constants, FSM state type and select-order helpers for the mux scan controller.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Channel visited first in a scan.
  function automatic logic [SEL_W-1:0] first_sel(input bit rev);
    return rev ? SEL_W'(NUM_CH - 1) : SEL_W'(0);
  endfunction

  // Channel visited last in a scan; reaching it ends the scan.
  function automatic logic [SEL_W-1:0] last_sel(input bit rev);
    return rev ? SEL_W'(0) : SEL_W'(NUM_CH - 1);
  endfunction

  // Channel following sel in scan order.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input bit rev);
    return rev ? SEL_W'(sel - SEL_W'(1)) : SEL_W'(sel + SEL_W'(1));
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Per-channel dwell timer: counts enabled cycles and flags the last cycle of a dwell.
module dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Last dwell cycle is reached when the count equals DWELL-1.
  assign tick = en && (cnt_q == CW'(DWELL - 1));

  // Next count: clear wins, wrap to zero on tick, otherwise step while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer that drives a 4:1 bit mux through all channels and reassembles the word it sees.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL   = 1,
  parameter bit REVERSE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] data_in,
  output logic [NUM_CH-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] data_out,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic              err,
  output logic              busy
);

  // A zero or negative dwell would never produce a sample.
  if (DWELL < 1) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be >= 1");
  end

  state_e            state_q,    state_d;
  logic [NUM_CH-1:0] mux_in_q,   mux_in_d;
  logic [SEL_W-1:0]  mux_sel_q,  mux_sel_d;
  logic [NUM_CH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tick;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .en   (timer_en),
    .tick (timer_tick)
  );

  // Next-state, select stepping and sample capture.
  always_comb begin
    state_d    = state_q;
    mux_in_d   = mux_in_q;
    mux_sel_d  = mux_sel_q;
    data_out_d = data_out_q;
    ones_cnt_d = ones_cnt_q;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = SCAN;
          mux_in_d   = data_in;
          mux_sel_d  = first_sel(REVERSE);
          data_out_d = '0;
          ones_cnt_d = '0;
          timer_clr  = 1'b1;
        end
      end
      SCAN: begin
        timer_en = 1'b1;
        if (timer_tick) begin
          data_out_d[mux_sel_q] = mux_out;
          ones_cnt_d            = ones_cnt_q + CNT_W'(mux_out);
          if (mux_sel_q == last_sel(REVERSE)) begin
            state_d = DONE;
          end else begin
            mux_sel_d = next_sel(mux_sel_q, REVERSE);
          end
        end
      end
      DONE: begin
        // Result and mux drive stay frozen until the consumer takes it.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mux_in_q   <= '0;
      mux_sel_q  <= '0;
      data_out_q <= '0;
      ones_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mux_in_q   <= mux_in_d;
      mux_sel_q  <= mux_sel_d;
      data_out_q <= data_out_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  // Handshake and status decode straight from registered state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SCAN) || (state_q == DONE);
  assign err       = (state_q == DONE) && (data_out_q != mux_in_q);

  assign mux_in   = mux_in_q;
  assign mux_sel  = mux_sel_q;
  assign data_out = data_out_q;
  assign ones_cnt = ones_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: two controllers (DWELL=1 forward, DWELL=3 reverse), each driving a behavioural 4:1 mux.
module tb_mux_scan_ctrl;

  logic clk;
  logic rst;

  logic       in_valid   [2];
  logic       in_ready_w [2];
  logic [3:0] data_in    [2];
  logic [3:0] mux_in_w   [2];
  logic [1:0] mux_sel_w  [2];
  logic       mux_out    [2];
  logic       out_valid_w[2];
  logic       out_ready  [2];
  logic [3:0] data_out_w [2];
  logic [2:0] ones_cnt_w [2];
  logic       err_w      [2];
  logic       busy_w     [2];
  logic       force_zero [2];

  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_scan_ctrl #(
      .DWELL   ((g == 0) ? 1 : 3),
      .REVERSE (g == 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready_w[g]),
      .data_in   (data_in[g]),
      .mux_in    (mux_in_w[g]),
      .mux_sel   (mux_sel_w[g]),
      .mux_out   (mux_out[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out_w[g]),
      .ones_cnt  (ones_cnt_w[g]),
      .err       (err_w[g]),
      .busy      (busy_w[g])
    );

    // Behavioural 4:1 mux; force_zero models a stuck-at-0 on channel 2.
    assign mux_out[g] = (force_zero[g] && (mux_sel_w[g] == 2'd2)) ? 1'b0
                                                                  : mux_in_w[g][mux_sel_w[g]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dwell_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one edge and confirm it was taken.
  task automatic do_accept(input int u, input logic [3:0] word);
    check("in_ready_pre", 32'(in_ready_w[u]), 32'd1);
    data_in[u]  = word;
    in_valid[u] = 1'b1;
    step();
    in_valid[u] = 1'b0;
    check("busy_after_accept", 32'(busy_w[u]), 32'd1);
    check("in_ready_after_accept", 32'(in_ready_w[u]), 32'd0);
  endtask

  // Follow the scan, checking the select sequence and the latency to out_valid.
  task automatic wait_done(input int u);
    int edges;
    int sel_bad;
    int idx;
    int exp_sel;
    edges   = 1;
    sel_bad = 0;
    while (!out_valid_w[u] && edges < 200) begin
      idx     = (edges - 1) / dwell_of(u);
      exp_sel = (u == 1) ? (3 - idx) : idx;
      if (32'(mux_sel_w[u]) != 32'(exp_sel)) sel_bad++;
      step();
      edges++;
    end
    check("sel_sequence", 32'(sel_bad), 32'd0);
    check("latency_edges", 32'(edges), 32'(4 * dwell_of(u) + 1));
  endtask

  task automatic check_result(input int u, input logic [3:0] word, input logic [3:0] exp_d,
                              input logic [2:0] exp_ones, input logic exp_err);
    check("out_valid", 32'(out_valid_w[u]), 32'd1);
    check("data_out", 32'(data_out_w[u]), 32'(exp_d));
    check("ones_cnt", 32'(ones_cnt_w[u]), 32'(exp_ones));
    check("err", 32'(err_w[u]), 32'(exp_err));
    check("mux_in_hold", 32'(mux_in_w[u]), 32'(word));
  endtask

  // Hand the result to the consumer; in_ready must rise only afterwards.
  task automatic do_release(input int u);
    check("in_ready_in_done", 32'(in_ready_w[u]), 32'd0);
    out_ready[u] = 1'b1;
    step();
    out_ready[u] = 1'b0;
    check("out_valid_after_release", 32'(out_valid_w[u]), 32'd0);
    check("in_ready_after_release", 32'(in_ready_w[u]), 32'd1);
    check("busy_after_release", 32'(busy_w[u]), 32'd0);
    check("sel_hold_after_release", 32'(mux_sel_w[u]), (u == 1) ? 32'd0 : 32'd3);
  endtask

  task automatic run_scan(input int u, input logic [3:0] word, input logic [3:0] exp_d,
                          input logic [2:0] exp_ones, input logic exp_err);
    do_accept(u, word);
    wait_done(u);
    check_result(u, word, exp_d, exp_ones, exp_err);
    do_release(u);
  endtask

  task automatic check_reset_state(input int u);
    check("rst_in_ready", 32'(in_ready_w[u]), 32'd1);
    check("rst_out_valid", 32'(out_valid_w[u]), 32'd0);
    check("rst_mux_sel", 32'(mux_sel_w[u]), 32'd0);
    check("rst_mux_in", 32'(mux_in_w[u]), 32'd0);
    check("rst_data_out", 32'(data_out_w[u]), 32'd0);
    check("rst_ones_cnt", 32'(ones_cnt_w[u]), 32'd0);
    check("rst_busy", 32'(busy_w[u]), 32'd0);
    check("rst_err", 32'(err_w[u]), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]   = 1'b0;
      data_in[i]    = 4'd0;
      out_ready[i]  = 1'b0;
      force_zero[i] = 1'b0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state(0);
    check_reset_state(1);

    // T2: forward scan, single-cycle dwell.
    run_scan(0, 4'b1011, 4'b1011, 3'd3, 1'b0);

    // T3: reverse scan, three-cycle dwell.
    run_scan(1, 4'b0110, 4'b0110, 3'd2, 1'b0);

    // T4: zero word still takes the full scan.
    run_scan(0, 4'b0000, 4'b0000, 3'd0, 1'b0);
    run_scan(1, 4'b0000, 4'b0000, 3'd0, 1'b0);

    // T5: consumer stalls six cycles while the producer keeps offering a new word.
    do_accept(1, 4'b1001);
    wait_done(1);
    data_in[1]  = 4'b0101;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check_result(1, 4'b1001, 4'b1001, 3'd2, 1'b0);
      check("bp_in_ready", 32'(in_ready_w[1]), 32'd0);
      step();
    end
    check_result(1, 4'b1001, 4'b1001, 3'd2, 1'b0);
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;
    check("bp_in_ready_return", 32'(in_ready_w[1]), 32'd1);
    check("bp_out_valid_drop", 32'(out_valid_w[1]), 32'd0);
    check("bp_mux_in_unchanged", 32'(mux_in_w[1]), 32'(4'b1001));
    in_valid[1] = 1'b0;
    step();
    check("bp_no_accept", 32'(busy_w[1]), 32'd0);

    // T6: channel 2 stuck low is caught by the self-check.
    force_zero[0] = 1'b1;
    run_scan(0, 4'b1111, 4'b1011, 3'd3, 1'b1);
    force_zero[0] = 1'b0;

    // T1: reset in the middle of a reverse scan abandons it.
    do_accept(1, 4'b1111);
    repeat (4) step();
    check("mid_scan_busy", 32'(busy_w[1]), 32'd1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state(1);
    step();
    check("post_rst_no_valid", 32'(out_valid_w[1]), 32'd0);

    // Normal operation resumes after the reset.
    run_scan(1, 4'b1100, 4'b1100, 3'd2, 1'b0);
    run_scan(0, 4'b0111, 4'b0111, 3'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
